// File: rtl/intra_pkg.sv
// Shared sample type, FSM states and stream/writeback index constants for intra neighbour fetch.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package intra_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        STREAM
    } nbr_state_t;

    // Samples per neighbour stream, without and with the top-right extension.
    localparam int NBR_CNT    = 33;
    localparam int NBR_CNT_TR = 41;

    // Value emitted for a neighbour that lies outside the picture.
    localparam int NBR_UNAVAIL = 128;

    // Writeback index map: bottom row x, then right column y.
    localparam int WB_ROW_LO = 0;
    localparam int WB_ROW_HI = 15;
    localparam int WB_COL_LO = 16;
    localparam int WB_COL_HI = 31;

    // Stream index map: top-left, top row, left column, optional top-right.
    localparam int IDX_TL      = 0;
    localparam int IDX_TOP_HI  = 16;
    localparam int IDX_LEFT_HI = 32;

endpackage

// File: rtl/mb_divmod.sv
// Sequential divide of an MB number by the picture width: mby = quotient, mbx = remainder.
// Latency: mby+1 cycles from start to the done pulse; results hold until the next start.
// Backpressure: none; start is only issued while idle, done is a single-cycle pulse.
module mb_divmod #(
    parameter int PIC_WIDTH_MB = 120,
    parameter int MBNUM_W      = 13,
    parameter int MBX_W        = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MBNUM_W-1:0] mbnumber,
    output logic               done,
    output logic [MBX_W-1:0]   mbx,
    output logic [MBNUM_W-1:0] mby
);

    logic [MBNUM_W-1:0] rem_q;
    logic [MBNUM_W-1:0] quo_q;
    logic               busy_q;
    logic               fits;

    assign fits = (rem_q < MBNUM_W'(PIC_WIDTH_MB));
    assign done = busy_q & fits;
    assign mbx  = rem_q[MBX_W-1:0];
    assign mby  = quo_q;

    // Subtract one picture width per cycle until the remainder fits in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= mbnumber;
            quo_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (fits) begin
                busy_q <= 1'b0;
            end else begin
                rem_q <= rem_q - MBNUM_W'(PIC_WIDTH_MB);
                quo_q <= quo_q + MBNUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/intra_nbr_fetch.sv
// Neighbour-sample responder: stores writeback rows/columns, streams one MB's luma neighbours to intrapred.
// Latency: request -> CALC for mby+1 cycles -> first sample valid; 33 (41 with INTRA_NBR_TOPRIGHT_EN) samples.
// Backpressure: nbr_valid/nbr_ready, outputs hold while stalled; req_ready only in IDLE; writeback never stalls.
module intra_nbr_fetch
    import intra_pkg::*;
#(
    parameter int PIC_WIDTH_MB = 120,
    parameter int PIX_W        = 8,
    parameter int MBNUM_W      = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MBNUM_W-1:0] req_mbnumber,
    output logic               nbr_valid,
    input  logic               nbr_ready,
    output logic [PIX_W-1:0]   nbr_data,
    output logic [5:0]         nbr_idx,
    output logic               nbr_last,
    output logic               avail_top,
    output logic               avail_left,
    output logic               avail_topleft,
`ifdef INTRA_NBR_TOPRIGHT_EN
    output logic               avail_topright,
`endif
    input  logic               wb_valid,
    input  logic [MBNUM_W-1:0] wb_mbnumber,
    input  logic [4:0]         wb_idx,
    input  logic [PIX_W-1:0]   wb_data
);

    localparam int MBX_W      = $clog2(PIC_WIDTH_MB);
    localparam int LINE_AW    = MBX_W + 4;
    localparam int LINE_DEPTH = PIC_WIDTH_MB * 16;
    localparam logic [PIX_W-1:0] UNAVAIL = {1'b1, {(PIX_W-1){1'b0}}};
`ifdef INTRA_NBR_TOPRIGHT_EN
    localparam logic [5:0] LAST_IDX = 6'(NBR_CNT_TR - 1);
`else
    localparam logic [5:0] LAST_IDX = 6'(NBR_CNT - 1);
`endif

    nbr_state_t state_q;
    nbr_state_t state_d;

    logic               div_start;
    logic               div_done;
    logic [MBX_W-1:0]   div_mbx;
    logic [MBNUM_W-1:0] div_mby;

    // Availability derived straight from the divider; its outputs hold through STREAM.
    logic c_top;
    logic c_left;
    logic c_tl;
`ifdef INTRA_NBR_TOPRIGHT_EN
    logic             c_tr;
    logic [MBX_W-1:0] mbx_inc;
`endif

    logic             nbr_fire;
    logic [5:0]       nxt_idx;
    logic [3:0]       nxt_x;
    logic [PIX_W-1:0] nxt_dat;

    logic [PIX_W-1:0]   line_mem [LINE_DEPTH];
    logic [PIX_W-1:0]   left_q [16];
    logic [PIX_W-1:0]   corner_q;
    logic [MBX_W-1:0]   wb_col_q;
    logic [MBX_W-1:0]   wb_col;
    logic [LINE_AW-1:0] wb_addr;

    mb_divmod #(
        .PIC_WIDTH_MB (PIC_WIDTH_MB),
        .MBNUM_W      (MBNUM_W),
        .MBX_W        (MBX_W)
    ) u_divmod (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .mbnumber (req_mbnumber),
        .done     (div_done),
        .mbx      (div_mbx),
        .mby      (div_mby)
    );

    assign c_top    = (div_mby != '0);
    assign c_left   = (div_mbx != '0);
    assign c_tl     = c_top & c_left;
`ifdef INTRA_NBR_TOPRIGHT_EN
    assign c_tr     = c_top & (div_mbx != MBX_W'(PIC_WIDTH_MB - 1));
    assign mbx_inc  = div_mbx + MBX_W'(1);
`endif
    assign nbr_fire = nbr_valid & nbr_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request acceptance and divider start.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset;
                if (req_valid && reset) begin
                    div_start = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (div_done) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (nbr_fire && nbr_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Index of the sample to load next: 0 when leaving CALC, otherwise the one after the current.
    always_comb begin
        nxt_idx = (state_q == STREAM) ? (nbr_idx + 6'd1) : 6'd0;
        nxt_x   = nxt_idx[3:0] - 4'd1;
    end

    // Neighbour sample selection for nxt_idx; unavailable positions read as mid-grey.
    always_comb begin
        nxt_dat = UNAVAIL;
        if (nxt_idx == 6'(IDX_TL)) begin
            if (c_tl) nxt_dat = corner_q;
        end else if (nxt_idx <= 6'(IDX_TOP_HI)) begin
            if (c_top) nxt_dat = line_mem[{div_mbx, nxt_x}];
        end else if (nxt_idx <= 6'(IDX_LEFT_HI)) begin
            if (c_left) nxt_dat = left_q[nxt_x];
        end
`ifdef INTRA_NBR_TOPRIGHT_EN
        else if (c_top) begin
            nxt_dat = c_tr ? line_mem[{mbx_inc, nxt_x}] : line_mem[{div_mbx, 4'hF}];
        end
`endif
    end

    // Output stage: load on CALC exit, advance on each handshake, drop after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nbr_valid <= 1'b0;
            nbr_last  <= 1'b0;
            nbr_data  <= '0;
            nbr_idx   <= '0;
        end else if (state_q == CALC && div_done) begin
            nbr_valid <= 1'b1;
            nbr_last  <= 1'b0;
            nbr_data  <= nxt_dat;
            nbr_idx   <= nxt_idx;
        end else if (state_q == STREAM && nbr_fire) begin
            if (nbr_last) begin
                nbr_valid <= 1'b0;
                nbr_last  <= 1'b0;
            end else begin
                nbr_data <= nxt_dat;
                nbr_idx  <= nxt_idx;
                nbr_last <= (nxt_idx == LAST_IDX);
            end
        end
    end

    // Availability flags: captured on CALC exit, cleared when the stream completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avail_top      <= 1'b0;
            avail_left     <= 1'b0;
            avail_topleft  <= 1'b0;
`ifdef INTRA_NBR_TOPRIGHT_EN
            avail_topright <= 1'b0;
`endif
        end else if (state_q == CALC && div_done) begin
            avail_top      <= c_top;
            avail_left     <= c_left;
            avail_topleft  <= c_tl;
`ifdef INTRA_NBR_TOPRIGHT_EN
            avail_topright <= c_tr;
`endif
        end else if (state_q == STREAM && nbr_fire && nbr_last) begin
            avail_top      <= 1'b0;
            avail_left     <= 1'b0;
            avail_topleft  <= 1'b0;
`ifdef INTRA_NBR_TOPRIGHT_EN
            avail_topright <= 1'b0;
`endif
        end
    end

    // MB 0 restarts the column tracker, so its row lands in column 0 regardless of history.
    assign wb_col  = (wb_mbnumber == '0) ? '0 : wb_col_q;
    assign wb_addr = {wb_col, wb_idx[3:0]};

    // Line buffer write; no reset, contents are always rewritten before they are read as available.
    always_ff @(posedge clk) begin
        if (wb_valid && wb_idx <= 5'(WB_ROW_HI)) begin
            line_mem[wb_addr] <= wb_data;
        end
    end

    // Left column, top-left corner capture and writeback column tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                left_q[i] <= '0;
            end
            corner_q <= '0;
            wb_col_q <= '0;
        end else if (wb_valid) begin
            if (wb_idx >= 5'(WB_COL_LO)) begin
                left_q[4'(wb_idx - 5'(WB_COL_LO))] <= wb_data;
            end
            // The sample being overwritten is the bottom-right of the MB above; it is the
            // top-left of the next MB.
            if (wb_idx == 5'(WB_ROW_HI)) begin
                corner_q <= line_mem[wb_addr];
            end
            if (wb_idx == 5'(WB_COL_HI)) begin
                wb_col_q <= (wb_col == MBX_W'(PIC_WIDTH_MB - 1)) ? '0 : (wb_col + MBX_W'(1));
            end else if (wb_mbnumber == '0) begin
                wb_col_q <= '0;
            end
        end
    end

endmodule

// File: doc/intra_nbr_fetch.md
Name: intra_nbr_fetch

Overview:
- Neighbour-sample responder for intrapred.
- Stores reconstructed bottom rows and right columns written back after each macroblock.
- On a request carrying an mbnumber, streams that MB's luma neighbours to intrapred, with availability flags, over a valid/ready handshake.
- Sits between the reconstruction writeback path and intrapred's neighbour input.

Parameters:
- PIC_WIDTH_MB, 120: picture width in macroblocks.
- PIX_W, 8: sample width in bits.
- MBNUM_W, 13: macroblock number width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  neighbour request
- req_ready  out  1  block can accept a request
- req_mbnumber  in  MBNUM_W  raster-order MB index of the request
- nbr_valid  out  1  nbr_data valid
- nbr_ready  in  1  intrapred accepts the sample
- nbr_data  out  PIX_W  neighbour sample
- nbr_idx  out  6  sample index within the stream
- nbr_last  out  1  final sample of the stream
- avail_top  out  1  top neighbours exist
- avail_left  out  1  left neighbours exist
- avail_topleft  out  1  top-left neighbour exists
- wb_valid  in  1  writeback sample strobe; no backpressure
- wb_mbnumber  in  MBNUM_W  MB being written back
- wb_idx  in  5  0-15: bottom row x; 16-31: right column y
- wb_data  in  PIX_W  reconstructed sample

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - req_ready=0 during reset, then 1 in IDLE.
  - nbr_valid, nbr_last, nbr_data, nbr_idx and all avail_* outputs = 0.
  - Left-column and corner registers are cleared.
  - Line buffer (PIC_WIDTH_MB*16 x PIX_W) is not reset.
  - Reset mid-stream abandons the stream; nothing is emitted afterwards.
- State machine: IDLE -> CALC -> STREAM -> IDLE.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches req_mbnumber; next state is CALC.
  - CALC: sequential division, one subtraction of PIC_WIDTH_MB per cycle, producing mby (quotient) and mbx (remainder).
    - Leaves when remainder < PIC_WIDTH_MB.
    - Takes mby+1 cycles. Worst case 69 for 8191/120.
    - On exit, avail_left=(mbx!=0), avail_top=(mby!=0), avail_topleft=both. These are held until return to IDLE.
  - STREAM: emits 33 samples in order, idx 0..32.
    - idx 0: top-left.
    - idx 1-16: top row x=0..15, from line[mbx*16+x].
    - idx 17-32: left column y=0..15, from the left register.
    - An unavailable sample outputs 1<<(PIX_W-1), i.e. 128.
    - nbr_idx advances only on nbr_valid & nbr_ready. nbr_data and nbr_idx hold while stalled.
    - nbr_last=1 with idx 32. That handshake returns to IDLE on the next cycle, so req_ready is high on the cycle after the last handshake.
- Writeback:
  - Always accepted, in every state.
  - wb_idx 0-15 writes line[(wb_mbnumber mod PIC_WIDTH_MB)*16+wb_idx]. The column is taken from an internal writeback column counter: reset to 0, incremented when wb_idx=31 is written, wrapped at PIC_WIDTH_MB, and cleared when wb_mbnumber=0.
  - wb_idx 16-31 writes left[wb_idx-16].
  - On wb_idx=15, the old line value at that address is first copied to the corner register. The corner register supplies top-left for the next MB.
  - A read and a write to the same address in the same cycle return the old data.
- Request order:
  - Requests arrive in raster order.
  - Writeback of MB n completes before the request for MB n+1.
  - Behaviour is undefined otherwise.

Optional Feature:
- Macro: INTRA_NBR_TOPRIGHT_EN.
- Defined:
  - Stream extends to 41 samples. idx 33-40 are top-right x=16..23 from line[(mbx+1)*16+x-16].
  - New output avail_topright = avail_top & (mbx != PIC_WIDTH_MB-1).
  - If avail_topright=0 but avail_top=1, idx 33-40 repeat the top sample x=15. If avail_top=0, they are 128.
  - nbr_last moves to idx 40.
- Undefined: 33 samples, no avail_topright port.

Decomposition:
- Package intra_pkg holds:
  - Sample type pix_t.
  - Enum nbr_state_t {IDLE, CALC, STREAM}.
  - Constants NBR_CNT=33 and NBR_CNT_TR=41.
  - Constant NBR_UNAVAIL=128.
  - wb_idx range constants.
- One sub-module, mb_divmod: the sequential divide/modulo of mbnumber by PIC_WIDTH_MB, with start/done.

Test Plan:
- Request mbnumber=0, nbr_ready=1 -> CALC takes 1 cycle; all avail_*=0; 33 samples, all 128; nbr_last at idx 32; req_ready high the next cycle.
- Write back MB0 bottom row 0x10..0x1F and right column 0x20..0x2F, then request mbnumber=1 -> avail_left=1, avail_top=0; idx 0-16 = 128; idx 17-32 = 0x20..0x2F.
- Write back MB0..MB120 with bottom row = MB number; request 121 -> CALC 2 cycles; avail_top=1, avail_left=1, avail_topleft=1; top row = 1; top-left = 0 (corner of MB0).
- Request 8191 -> CALC 69 cycles; mbx=31, mby=68; no handshake during CALC.
- Toggle nbr_ready 1,0,0,1 mid-stream -> nbr_idx/nbr_data held while stalled; no sample skipped or duplicated; still exactly 33 handshakes.
- Assert reset at idx 10 -> nbr_valid=0 immediately; after release, req_ready=1 and a fresh request streams from idx 0.
